// File: rtl/accumulator_memory.sv
// Shared-bus operand memory and arbiter for the parallel accumulator: a circular
// operand buffer plus a round-robin arbiter that reserves second operands.
module accumulator_memory #(
  parameter int N_PROC = 4,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_PROC-1:0] req,
  output logic [N_PROC-1:0] grant,
  input  logic [1:0]        op,
  output logic [31:0]       read,
  input  logic [31:0]       write,
  output logic              signal,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  output logic              load_ready,
  input  logic              start,
  output logic              done,
  output logic [31:0]       sum,
  output logic              error
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(N_PROC);
  localparam logic [1:0]  OP_FETCH = 2'b01;
  localparam logic [1:0]  OP_SEND  = 2'b10;
  localparam logic [AW:0] ONE      = (AW+1)'(1);
  localparam logic [AW:0] TWO      = (AW+1)'(2);
  localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {S_LOAD, S_ARB, S_GNT, S_ACK, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [AW:0]       count_q, count_d, reserved_q, reserved_d;
  logic [1:0]        ph_q [N_PROC];
  logic [1:0]        ph_d [N_PROC];
  logic [IW-1:0]     rr_q, rr_d, gidx_q, gidx_d;
  logic [N_PROC-1:0] grant_q, grant_d;
  logic              signal_q, signal_d, load_ready_q, load_ready_d;
  logic              done_q, done_d, error_q, error_d;
  logic [31:0]       read_q, read_d, sum_q, sum_d;

  logic [31:0]       mem [DEPTH];
  logic              mem_we;
  logic [31:0]       mem_wdata;

  logic [AW:0]       avail;
  logic [N_PROC-1:0] eligible;
  logic              all_idle, pick_found;
  logic [IW-1:0]     pick_idx;
  int                cand;

  // A phase-0 processor is only eligible when two unreserved operands exist,
  // so a first fetch can never strand a processor waiting for its second.
  always_comb begin
    avail      = count_q - reserved_q;
    all_idle   = 1'b1;
    eligible   = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 0; i < N_PROC; i++) begin
      eligible[i] = req[i] && ((ph_q[i] != 2'd0) || (avail >= TWO));
      if (ph_q[i] != 2'd0) all_idle = 1'b0;
    end
    for (int k = 0; k < N_PROC; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= N_PROC) cand = cand - N_PROC;
      if (!pick_found && eligible[IW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    reserved_d = reserved_q;
    ph_d       = ph_q;
    rr_d       = rr_q;
    gidx_d     = gidx_q;
    grant_d    = grant_q;
    signal_d   = signal_q;
    done_d     = done_q;
    error_d    = error_q;
    read_d     = read_q;
    sum_d      = sum_q;
    mem_we     = 1'b0;
    mem_wdata  = write;
    case (state_q)
      S_LOAD: begin
        if (start) begin
          if (count_q <= ONE) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            sum_d   = (count_q == '0) ? '0 : mem[head_q];
          end else begin
            state_d = S_ARB;
          end
        end else if (load_valid && load_ready_q) begin
          mem_we    = 1'b1;
          mem_wdata = load_data;
          tail_d    = tail_q + AW'(1);
          count_d   = count_q + ONE;
        end
      end
      S_ARB: begin
        if (pick_found) begin
          grant_d = N_PROC'(1) << pick_idx;
          gidx_d  = pick_idx;
          state_d = S_GNT;
        end else if (count_q == ONE && reserved_q == '0 && all_idle) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          sum_d   = mem[head_q];
        end
      end
      S_GNT: begin
        if (op == OP_FETCH && ph_q[gidx_q] != 2'd2) begin
          read_d   = mem[head_q];
          head_d   = head_q + AW'(1);
          count_d  = count_q - ONE;
          signal_d = 1'b1;
          state_d  = S_ACK;
          if (ph_q[gidx_q] == 2'd0) begin
            ph_d[gidx_q] = 2'd1;
            reserved_d   = reserved_q + ONE;
          end else begin
            ph_d[gidx_q] = 2'd2;
            reserved_d   = reserved_q - ONE;
          end
        end else if (op == OP_SEND && ph_q[gidx_q] == 2'd2) begin
          mem_we       = 1'b1;
          tail_d       = tail_q + AW'(1);
          count_d      = count_q + ONE;
          signal_d     = 1'b1;
          ph_d[gidx_q] = 2'd0;
          state_d      = S_ACK;
        end else if (op == OP_FETCH || op == OP_SEND) begin
          error_d = 1'b1;
          grant_d = '0;
          state_d = S_ARB;
        end
      end
      S_ACK: begin
        signal_d = 1'b0;
        grant_d  = '0;
        rr_d     = (gidx_q == IW'(N_PROC - 1)) ? '0 : gidx_q + IW'(1);
        state_d  = S_ARB;
      end
      S_DONE:  ;
      default: state_d = S_LOAD;
    endcase
    load_ready_d = (state_d == S_LOAD) && (count_d < FULL);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_LOAD;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      reserved_q   <= '0;
      for (int i = 0; i < N_PROC; i++) ph_q[i] <= 2'd0;
      rr_q         <= '0;
      gidx_q       <= '0;
      grant_q      <= '0;
      signal_q     <= 1'b0;
      load_ready_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      read_q       <= '0;
      sum_q        <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      reserved_q   <= reserved_d;
      ph_q         <= ph_d;
      rr_q         <= rr_d;
      gidx_q       <= gidx_d;
      grant_q      <= grant_d;
      signal_q     <= signal_d;
      load_ready_q <= load_ready_d;
      done_q       <= done_d;
      error_q      <= error_d;
      read_q       <= read_d;
      sum_q        <= sum_d;
    end
  end

  // NOTE: the operand array has no reset; count and pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem[tail_q] <= mem_wdata;
  end

  assign grant      = grant_q;
  assign signal     = signal_q;
  assign read       = read_q;
  assign load_ready = load_ready_q;
  assign done       = done_q;
  assign sum        = sum_q;
  assign error      = error_q;

endmodule

// File: tb/tb_accumulator_memory.sv
// Self-checking bench for accumulator_memory: bench-side processors drive the bus
// and a queue-based operand-pool model predicts every read, grant and final sum.
module tb_accumulator_memory;
  localparam int N_PROC = 4;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [N_PROC-1:0] req;
  logic [N_PROC-1:0] grant;
  logic [1:0]        op;
  logic [31:0]       read;
  logic [31:0]       write;
  logic              signal;
  logic              load_valid;
  logic [31:0]       load_data;
  logic              load_ready;
  logic              start;
  logic              done;
  logic [31:0]       sum;
  logic              error;

  accumulator_memory #(.N_PROC(N_PROC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant), .op(op), .read(read),
    .write(write), .signal(signal), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .start(start), .done(done), .sum(sum), .error(error)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mq[$];
  int          m_ph [N_PROC];
  logic [31:0] m_a  [N_PROC];
  logic [31:0] m_b  [N_PROC];
  logic [31:0] exp_sum;
  int          grant_log[$];

  task automatic do_reset();
    reset = 1'b0; req = '0; op = 2'b00; write = '0;
    load_valid = 1'b0; load_data = '0; start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    mq.delete();
    grant_log.delete();
    exp_sum = '0;
    for (int i = 0; i < N_PROC; i++) begin m_ph[i] = 0; m_a[i] = '0; m_b[i] = '0; end
    @(negedge clk);
  endtask

  task automatic load_word(input logic [31:0] w);
    logic exp_ready;
    exp_ready = (mq.size() < DEPTH);
    n_checks++;
    if (load_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL load_ready: got %b want %b (pool %0d)", load_ready, exp_ready, mq.size());
    end
    load_valid = 1'b1;
    load_data  = w;
    @(negedge clk);
    load_valid = 1'b0;
    if (exp_ready) begin
      mq.push_back(w);
      exp_sum = exp_sum + w;
    end
  endtask

  task automatic pulse_start(input bit with_load);
    start = 1'b1;
    if (with_load) begin load_valid = 1'b1; load_data = 32'h0BAD_F00D; end
    @(negedge clk);
    start = 1'b0;
    load_valid = 1'b0;
  endtask

  // Bench processors: each follows fetch A, fetch B, send A+B while requesting.
  task automatic run_procs(input logic [N_PROC-1:0] active, input bit rand_delay);
    bit finished;
    int gi, w, m_res, busy;
    logic [N_PROC-1:0] g;
    logic [31:0] exp_rd;
    finished = 0;
    req = active;
    for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        finished = 1;
        req = '0;
        busy = 0;
        for (int i = 0; i < N_PROC; i++) if (m_ph[i] != 0) busy++;
        n_checks++;
        if (sum !== exp_sum) begin
          n_fail++; $display("FAIL final_sum: got %0d want %0d", sum, exp_sum);
        end
        n_checks++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL error_clean: got %b want 0", error); end
        n_checks++;
        if (mq.size() > 1 || busy != 0) begin
          n_fail++; $display("FAIL done_early: pool %0d busy %0d want pool<=1 busy 0", mq.size(), busy);
        end
      end else if (grant !== '0) begin
        g = grant;
        gi = -1;
        for (int i = N_PROC - 1; i >= 0; i--) if (g[i]) gi = i;
        n_checks++;
        if ($countones(g) != 1 || !active[gi]) begin
          n_fail++; $display("FAIL grant_onehot: got %b active %b", g, active);
          req = '0; finished = 1;
        end else begin
          grant_log.push_back(gi);
          m_res = 0;
          for (int i = 0; i < N_PROC; i++) if (m_ph[i] == 1) m_res++;
          if (m_ph[gi] == 0) begin
            n_checks++;
            if (mq.size() - m_res < 2) begin
              n_fail++; $display("FAIL grant_avail: P%0d granted with avail %0d want >=2", gi, mq.size() - m_res);
            end
          end
          if (rand_delay) begin
            repeat ($urandom_range(0, 2)) begin
              op = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
              @(negedge clk);
            end
          end
          if (m_ph[gi] == 2) begin op = 2'b10; write = m_a[gi] + m_b[gi]; end
          else op = 2'b01;
          @(negedge clk);
          w = 1;
          while (signal !== 1'b1 && w < 6) begin @(negedge clk); w++; end
          n_checks++;
          if (signal !== 1'b1 || grant !== g) begin
            n_fail++; $display("FAIL ack: signal %b grant %b want 1 %b", signal, grant, g);
          end else if (m_ph[gi] == 2) begin
            mq.push_back(m_a[gi] + m_b[gi]);
            m_ph[gi] = 0;
          end else begin
            exp_rd = (mq.size() > 0) ? mq.pop_front() : 32'hx;
            n_checks++;
            if (read !== exp_rd) begin
              n_fail++; $display("FAIL read: P%0d got %0d want %0d", gi, read, exp_rd);
            end
            if (m_ph[gi] == 0) m_a[gi] = read; else m_b[gi] = read;
            m_ph[gi] = m_ph[gi] + 1;
          end
          op = 2'b00;
          @(negedge clk);
          n_checks++;
          if (signal !== 1'b0 || grant !== '0) begin
            n_fail++; $display("FAIL ack_one_cycle: signal %b grant %b want 0 0", signal, grant);
          end
        end
      end
    end
    if (!finished) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: done never rose");
      req = '0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req = '1; op = 2'b00; write = '0;
    load_valid = 1'b0; load_data = '0; start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({grant, signal, read, load_ready, done, sum, error} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: grant %b signal %b read %0d ready %b done %b sum %0d error %b want all 0",
               grant, signal, read, load_ready, done, sum, error);
    end
    reset = 1'b1;
    req = '0;
    #1;
    n_checks++;
    if (load_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b want 0", load_ready); end
    @(negedge clk);
    n_checks++;
    if (load_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge: got %b want 1", load_ready); end
  endtask

  task automatic test_single();
    do_reset();
    for (int i = 1; i <= 4; i++) load_word(32'(i));
    pulse_start(0);
    run_procs(4'b0001, 0);
    n_checks++;
    if (grant_log.size() != 9) begin
      n_fail++; $display("FAIL single_rounds: got %0d transactions want 9", grant_log.size());
    end
  endtask

  task automatic test_deadlock();
    do_reset();
    load_word(32'd5); load_word(32'd6); load_word(32'd7);
    pulse_start(0);
    run_procs(4'b0011, 0);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 1; i <= 8; i++) load_word(32'(i));
    pulse_start(1);
    run_procs(4'b1111, 0);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (grant_log.size() <= k || grant_log[k] != k) begin
        n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", k,
                           (grant_log.size() > k) ? grant_log[k] : -1, k);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) load_word($urandom);
    pulse_start(1);
    run_procs(4'($urandom_range(1, 15)), 1);
  endtask

  task automatic test_boundary();
    do_reset();
    pulse_start(0);
    run_procs(4'b1111, 0);
    do_reset();
    load_word($urandom);
    pulse_start(0);
    run_procs(4'b1111, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      do_reset();
      repeat ($urandom_range(2, 20)) load_word($urandom);
      pulse_start($urandom_range(0, 1) == 1);
      run_procs(4'($urandom_range(1, 15)), 1);
    end
  endtask

  task automatic test_error_and_reset();
    int w;
    do_reset();
    load_word(32'd1); load_word(32'd2); load_word(32'd3);
    pulse_start(0);
    req = 4'b0001;
    w = 0;
    while (grant !== 4'b0001 && w < 20) begin @(negedge clk); w++; end
    op = 2'b10;
    @(negedge clk);
    n_checks++;
    if (error !== 1'b1 || signal !== 1'b0 || grant !== '0) begin
      n_fail++; $display("FAIL bad_op: error %b signal %b grant %b want 1 0 0", error, signal, grant);
    end
    op = 2'b00;
    w = 0;
    while (grant !== 4'b0001 && w < 20) begin @(negedge clk); w++; end
    op = 2'b01;
    @(negedge clk);
    n_checks++;
    if (signal !== 1'b1 || read !== 32'd1) begin
      n_fail++; $display("FAIL fetch_after_error: signal %b read %0d want 1 1", signal, read);
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (signal !== 1'b0 || grant !== '0 || error !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: signal %b grant %b error %b want 0 0 0", signal, grant, error);
    end
    op = 2'b00; req = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_deadlock();
    test_round_robin();
    test_overflow();
    test_boundary();
    test_random();
    test_error_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accumulator_memory.md
# accumulator_memory

Shared-bus memory and arbiter that serves the `accumulator_processor` instances of the parallel accumulator. It holds the operand pool in a circular buffer and grants the bus to one processor at a time. It answers FETCH by supplying an operand and SEND by taking back a partial sum, and reports the final sum when one value remains and no processor holds data. Operand reservation is built into arbitration so that no processor stalls forever waiting for a second operand.

## Interface
- `N_PROC`, 4: number of processors on the bus (2–8).
- `DEPTH`, 32: operand buffer depth; power of two.
- `clk` in 1: clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in N_PROC: per-processor bus request.
- `grant` out N_PROC: one-hot bus grant, registered.
- `op` in 2: shared bus op; 01 = FETCH, 10 = SEND; any other value, including z or x, is NOP.
- `read` out 32: operand to the processors, registered.
- `write` in 32: partial sum from the processors.
- `signal` out 1: one-cycle transaction acknowledge, registered.
- `load_valid` in 1, `load_data` in 32, `load_ready` out 1: operand preload port, active only in LOAD.
- `start` in 1: single-cycle pulse that begins accumulation.
- `done` out 1: high while `sum` is valid.
- `sum` out 32: final result.
- `error` out 1: sticky protocol-violation flag.

## Operation
- States: LOAD, ARB, GNT, ACK, DONE.
- LOAD: `load_ready` = (count < DEPTH). On `load_valid && load_ready`, push `load_data`.
  - On `start`: go to DONE if count ≤ 1, else ARB. `start` wins over a simultaneous load; that load is dropped.
- Per-processor phase counter `ph[i]` ∈ {0: fetch A, 1: fetch B, 2: send}.
- `reserved` counts operands promised to phase-1 processors. avail = count − reserved.
- Eligibility for grant:
  - ph=0: req[i] && avail ≥ 2.
  - ph=1 or ph=2: req[i].
- ARB: round-robin among eligible requesters, starting at (last granted + 1) mod N_PROC. Set `grant[i]` and go to GNT.
- ARB with no eligible requester:
  - If count == 1, reserved == 0 and all ph == 0: go to DONE.
  - Otherwise stay in ARB.
- GNT: wait for `op` from the granted processor.
  - FETCH with ph ∈ {0,1}: `read` ← head, pop, `signal` ← 1, go to ACK.
    - ph 0→1: reserved+1.
    - ph 1→2: reserved−1.
  - SEND with ph = 2: push `write`, `signal` ← 1, ph → 0, go to ACK.
  - Op that does not match ph: set `error`, drop grant, return to ARB with no state change.
  - NOP: remain in GNT.
- ACK: `signal` and `grant` are high for this one cycle. `op` is ignored because the processor still drives it. Next edge: both clear, pointer updates, go to ARB.
- DONE: `sum` = head entry, or 0 if count == 0. `done` = 1. Leave only by reset.
- Pointers wrap mod DEPTH. count is log2(DEPTH)+1 bits. SEND never overflows, because every SEND follows two pops.
- Addition is done by the processors: 32-bit, wrapping, no carry out.

## Timing
- Reset values: `grant`=0, `signal`=0, `read`=0, `load_ready`=0, `done`=0, `sum`=0, `error`=0. State is LOAD; count, reserved, all ph, and the RR pointer (pointing at processor 0) are 0. `load_ready` rises one cycle after reset releases.
- Grant is driven on the first edge after an eligible req is seen in ARB.
- FETCH/SEND: `signal` rises on the edge after `op` is seen in GNT and stays high for exactly one cycle. `read` is stable while `signal` is high.
- `write` is sampled on the same edge that sets `signal`.
- Minimum one idle ARB cycle between transactions.
- Reset asserted mid-transaction: `grant` and `signal` drop immediately and all contents are discarded.

## Test plan
- Reset: hold `reset` low with `req`=1111 → all outputs 0. Release → `load_ready`=1 after one cycle.
- One processor, load 1,2,3,4, start → 3 fetch-fetch-send rounds, then `done`=1 and `sum`=10; `error`=0.
- Two processors, load 5,6,7 → while P1 is in ph=0 and avail=1, P1 is not granted. `sum`=18 with no deadlock.
- Four processors requesting simultaneously, load 1..8 → first grants in order 0,1,2,3 (round-robin); `sum`=36.
- Load 33 words → `load_ready` goes low after 32 and word 33 is ignored. Start → `sum` = sum of the first 32 words mod 2^32. A load pulsed together with `start` is dropped.
- P0 drives SEND while in ph=0 → `error`=1, no `signal`, grant released. Reset asserted during ACK → `signal` and `grant` drop immediately.
